// File: rtl/clk_pkg.sv
// Shared types and default timing constants for the PLL reset sequencer.
// Defaults target a 25.125 MHz PLL clock with a ~1 MHz symbol tick.
package clk_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABILIZE = 2'd1,
    RUN       = 2'd2,
    HOLDOFF   = 2'd3
  } pll_seq_state_t;

  localparam int DEF_STABLE_CYCLES = 1024;
  localparam int DEF_HOLD_CYCLES   = 256;
  localparam int DEF_ACC_WIDTH     = 16;
  localparam int DEF_TICK_INC      = 2608;

endpackage

// File: rtl/sync_ff2.sv
// Generic two-flop synchronizer for asynchronous inputs; 2-cycle latency.
// No backpressure; both stages clear to 0 on asynchronous active-high reset.
module sync_ff2 #(
  parameter int WIDTH = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_reset_sequencer.sv
// Qualifies PLL lock, sequences the system reset and emits a fractional-rate tick.
// Outputs registered off next state; no backpressure. PLL_LOCK_STATS_EN adds lock_loss_count.
module pll_reset_sequencer
  import clk_pkg::*;
#(
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
  parameter int ACC_WIDTH     = DEF_ACC_WIDTH,
  parameter int TICK_INC      = DEF_TICK_INC
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       locked_in,
  output logic       sys_reset,
  output logic       ready,
`ifdef PLL_LOCK_STATS_EN
  output logic       tick,
  output logic [7:0] lock_loss_count
`else
  output logic       tick
`endif
);

  localparam int CNT_MAX = (STABLE_CYCLES > HOLD_CYCLES) ? STABLE_CYCLES : HOLD_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [ACC_WIDTH:0] INC_EXT   = (ACC_WIDTH+1)'(TICK_INC);

  logic                 lock_s;
  pll_seq_state_t       state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [ACC_WIDTH:0]   acc_sum;
  logic                 stay_run;
  logic                 sys_reset_d, ready_d, tick_d;

  sync_ff2 #(.WIDTH(1)) u_lock_sync (
    .clock (clock),
    .reset (reset),
    .d     (locked_in),
    .q     (lock_s)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= WAIT_LOCK;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      WAIT_LOCK: if (lock_s) state_d = STABILIZE;
      STABILIZE: begin
        if (!lock_s)                  state_d = WAIT_LOCK;
        else if (cnt_q == STABLE_LAST) state_d = RUN;
      end
      RUN:       if (!lock_s) state_d = HOLDOFF;
      HOLDOFF:   if (cnt_q == HOLD_LAST) state_d = WAIT_LOCK;
      default:   state_d = WAIT_LOCK;
    endcase
  end

  // The shared counter only runs while dwelling in STABILIZE or HOLDOFF; any state change clears it.
  always_comb begin
    cnt_d = '0;
    if (state_d == state_q && (state_q == STABILIZE || state_q == HOLDOFF))
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_comb begin
    stay_run    = (state_q == RUN) && (state_d == RUN);
    acc_sum     = {1'b0, acc_q} + INC_EXT;
    acc_d       = stay_run ? acc_sum[ACC_WIDTH-1:0] : '0;
    tick_d      = stay_run & acc_sum[ACC_WIDTH];
    sys_reset_d = (state_d != RUN);
    ready_d     = (state_d == RUN);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc_q     <= '0;
      tick      <= 1'b0;
      sys_reset <= 1'b1;
      ready     <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      tick      <= tick_d;
      sys_reset <= sys_reset_d;
      ready     <= ready_d;
    end
  end

`ifdef PLL_LOCK_STATS_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      lock_loss_count <= '0;
    else if (state_q == RUN && state_d == HOLDOFF && lock_loss_count != 8'hFF)
      lock_loss_count <= lock_loss_count + 8'd1;
  end
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with short windows (STABLE=4, HOLD=3, TICK_INC=16384).
module tb_pll_reset_sequencer;

  logic clock = 1'b0;
  logic reset;
  logic locked_in;
  logic sys_reset, ready, tick;
`ifdef PLL_LOCK_STATS_EN
  logic [7:0] lock_loss_count;
`endif

  int vectors     = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  pll_reset_sequencer #(
    .STABLE_CYCLES (4),
    .HOLD_CYCLES   (3),
    .ACC_WIDTH     (16),
    .TICK_INC      (16384)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .locked_in (locked_in),
    .sys_reset (sys_reset),
    .ready     (ready),
`ifdef PLL_LOCK_STATS_EN
    .tick            (tick),
    .lock_loss_count (lock_loss_count)
`else
    .tick      (tick)
`endif
  );

  task automatic chk(input string tag, input int idx, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s[%0d]: observed %0h expected %0h", tag, idx, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input int idx, input logic exp_rst, input logic exp_tick);
    chk({tag, ".sys_reset"}, idx, {31'd0, sys_reset}, {31'd0, exp_rst});
    chk({tag, ".ready"},     idx, {31'd0, ready},     {31'd0, ~exp_rst});
    chk({tag, ".tick"},      idx, {31'd0, tick},      {31'd0, exp_tick});
  endtask

  task automatic adv();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    locked_in = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk_out("por", 0, 1'b1, 1'b0);
`ifdef PLL_LOCK_STATS_EN
    chk("por.count", 0, {24'd0, lock_loss_count}, 32'd0);
`endif

    // Acquisition: lock present before edge 0, release on edge 6.
    reset     = 1'b0;
    locked_in = 1'b1;
    for (int i = 0; i <= 6; i++) begin
      adv();
      chk_out("acq", i, (i < 6), 1'b0);
    end

    // RUN entered after edge 6: ticks after edges 10, 14, 18.
    for (int i = 7; i <= 19; i++) begin
      adv();
      chk_out("tick", i, 1'b0, ((i - 6) % 4) == 0);
    end

    // One-cycle lock drop sampled at edge 20; the would-be tick at edge 22 is suppressed.
    locked_in = 1'b0;
    adv();
    chk_out("loss", 20, 1'b0, 1'b0);
    locked_in = 1'b1;
    for (int i = 21; i <= 30; i++) begin
      adv();
      chk_out("loss", i, (i >= 22 && i < 30), 1'b0);
    end
`ifdef PLL_LOCK_STATS_EN
    chk("loss.count", 30, {24'd0, lock_loss_count}, 32'd1);
`endif

    // Accumulator restarts from 0 on re-entry: next tick after edge 34.
    for (int i = 31; i <= 34; i++) begin
      adv();
      chk_out("rerun", i, 1'b0, (i == 34));
    end

    // Asynchronous reset between edges while in RUN with tick high.
    #3;
    reset = 1'b1;
    #1;
    chk_out("arst", 0, 1'b1, 1'b0);
`ifdef PLL_LOCK_STATS_EN
    chk("arst.count", 0, {24'd0, lock_loss_count}, 32'd0);
`endif
    #1;
    reset = 1'b0;
    for (int i = 0; i <= 6; i++) begin
      adv();
      chk_out("reacq", i, (i < 6), 1'b0);
    end

    // Two-cycle lock drop during STABILIZE restarts qualification: release on edge 11.
    #3;
    reset = 1'b1;
    #2;
    reset     = 1'b0;
    locked_in = 1'b1;
    for (int i = 0; i <= 11; i++) begin
      adv();
      if (i == 2) locked_in = 1'b0;
      if (i == 4) locked_in = 1'b1;
      chk_out("glitch", i, (i < 11), 1'b0);
    end

`ifdef PLL_LOCK_STATS_EN
    chk("stats.start", 0, {24'd0, lock_loss_count}, 32'd0);
    for (int n = 1; n <= 300; n++) begin
      locked_in = 1'b0;
      adv();
      locked_in = 1'b1;
      repeat (10) adv();
      chk("stats.rerun", n, {31'd0, ready}, 32'd1);
      if (n == 1 || n == 255 || n == 256 || n == 300)
        chk("stats.count", n, {24'd0, lock_loss_count}, (n > 255) ? 32'd255 : n);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
